// File: rtl/ula_mc.sv
// Multi-cycle MIPS-style ALU. Single-cycle arithmetic/logic ops complete in one
// cycle; shifts run serially, one bit position per cycle, in the SHIFT state.
module ula_mc #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ALUOp,
    input  logic [5:0]       funct,
    input  logic [SHW-1:0]   shamt,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;
    typedef enum logic [1:0] {ShLl, ShRl, ShRa} shift_e;

    state_e           state_q, state_d;
    shift_e           kind_q, kind_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             illegal_q, illegal_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;

    // Decoded request
    logic             dec_shift;
    logic             dec_ill;
    shift_e           dec_kind;
    logic [SHW-1:0]   dec_amt;
    logic [WIDTH-1:0] alu_res;
    logic             slt_s;
    logic             slt_u;
    logic [WIDTH-1:0] shifted;

    // Decode the incoming request and compute the single-cycle result
    always_comb begin
        dec_shift = 1'b0;
        dec_ill   = 1'b0;
        dec_kind  = ShLl;
        dec_amt   = '0;
        alu_res   = '0;
        slt_s     = $signed(a) < $signed(b);
        slt_u     = a < b;
        unique case (ALUOp)
            3'b000: begin
                case (funct)
                    6'h20: alu_res = a + b;
                    6'h22: alu_res = a - b;
                    6'h24: alu_res = a & b;
                    6'h25: alu_res = a | b;
                    6'h26: alu_res = a ^ b;
                    6'h27: alu_res = ~(a | b);
                    6'h2A: alu_res = {{(WIDTH-1){1'b0}}, slt_s};
                    6'h2B: alu_res = {{(WIDTH-1){1'b0}}, slt_u};
                    6'h00: begin dec_shift = 1'b1; dec_kind = ShLl; dec_amt = shamt;      end
                    6'h02: begin dec_shift = 1'b1; dec_kind = ShRl; dec_amt = shamt;      end
                    6'h03: begin dec_shift = 1'b1; dec_kind = ShRa; dec_amt = shamt;      end
                    6'h04: begin dec_shift = 1'b1; dec_kind = ShLl; dec_amt = a[SHW-1:0]; end
                    6'h06: begin dec_shift = 1'b1; dec_kind = ShRl; dec_amt = a[SHW-1:0]; end
                    6'h07: begin dec_shift = 1'b1; dec_kind = ShRa; dec_amt = a[SHW-1:0]; end
                    default: dec_ill = 1'b1;
                endcase
            end
            3'b001: alu_res = a + b;
            3'b010: alu_res = a - b;
            3'b011: alu_res = a & b;
            3'b100: alu_res = a | b;
            3'b101: alu_res = a ^ b;
            3'b110: alu_res = {{(WIDTH-1){1'b0}}, slt_s};
            3'b111: alu_res = {{(WIDTH-1){1'b0}}, slt_u};
            default: alu_res = '0;
        endcase
    end

    // One-bit shift step applied to the working value held in result_q
    always_comb begin
        shifted = result_q;
        case (kind_q)
            ShLl:    shifted = {result_q[WIDTH-2:0], 1'b0};
            ShRl:    shifted = {1'b0, result_q[WIDTH-1:1]};
            ShRa:    shifted = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
            default: shifted = result_q;
        endcase
    end

    // FSM next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        zero_d      = zero_q;
        illegal_d   = illegal_q;
        out_valid_d = out_valid_q;
        case (state_q)
            StIdle: begin
                if (in_valid && in_ready_q) begin
                    illegal_d = dec_ill;
                    kind_d    = dec_kind;
                    if (dec_shift && (dec_amt != '0)) begin
                        state_d  = StShift;
                        cnt_d    = dec_amt;
                        result_d = b;
                        zero_d   = 1'b0;
                    end else begin
                        state_d     = StDone;
                        out_valid_d = 1'b1;
                        result_d    = dec_shift ? b : alu_res;
                        zero_d      = dec_shift ? (b == '0) : (alu_res == '0);
                    end
                end
            end
            StShift: begin
                result_d = shifted;
                cnt_d    = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    state_d     = StDone;
                    out_valid_d = 1'b1;
                    zero_d      = (shifted == '0);
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d     = StIdle;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
        // Held low through reset and for the first edge after release
        in_ready_d = (state_d == StIdle);
    end

    // State and output registers, asynchronously cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            kind_q      <= ShLl;
            cnt_q       <= '0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            illegal_q   <= illegal_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_ula_mc.sv
// Randomised plus directed bench for ula_mc (32-bit and 8-bit instances).
module tb_ula_mc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  alu_op = '0;
    logic [5:0]  funct = '0;
    logic [4:0]  shamt = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    logic        in_valid8 = 1'b0;
    logic        in_ready8;
    logic [2:0]  alu_op8 = '0;
    logic [5:0]  funct8 = '0;
    logic [2:0]  shamt8 = '0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        out_valid8;
    logic        out_ready8 = 1'b1;
    logic [7:0]  result8;
    logic        zero8;
    logic        illegal8;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ula_mc #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ALUOp(alu_op), .funct(funct), .shamt(shamt), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .illegal(illegal)
    );

    ula_mc #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .ALUOp(alu_op8), .funct(funct8), .shamt(shamt8), .a(a8), .b(b8),
        .out_valid(out_valid8), .out_ready(out_ready8), .result(result8),
        .zero(zero8), .illegal(illegal8)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: expected result, illegal flag and latency straight from the op table
    task automatic model(input logic [2:0] op, input logic [5:0] fn, input logic [4:0] sh,
                         input logic [31:0] ia, input logic [31:0] ib,
                         output logic [31:0] r, output logic ill, output int lat);
        int amt;
        r = 0; ill = 1'b0; lat = 1; amt = -1;
        case (op)
            3'd1: r = ia + ib;
            3'd2: r = ia - ib;
            3'd3: r = ia & ib;
            3'd4: r = ia | ib;
            3'd5: r = ia ^ ib;
            3'd6: r = ($signed(ia) < $signed(ib)) ? 32'd1 : 32'd0;
            3'd7: r = (ia < ib) ? 32'd1 : 32'd0;
            default: begin
                case (fn)
                    6'h20: r = ia + ib;
                    6'h22: r = ia - ib;
                    6'h24: r = ia & ib;
                    6'h25: r = ia | ib;
                    6'h26: r = ia ^ ib;
                    6'h27: r = ~(ia | ib);
                    6'h2A: r = ($signed(ia) < $signed(ib)) ? 32'd1 : 32'd0;
                    6'h2B: r = (ia < ib) ? 32'd1 : 32'd0;
                    6'h00: begin amt = sh;      r = ib << amt; end
                    6'h02: begin amt = sh;      r = ib >> amt; end
                    6'h03: begin amt = sh;      r = $signed(ib) >>> amt; end
                    6'h04: begin amt = ia[4:0]; r = ib << amt; end
                    6'h06: begin amt = ia[4:0]; r = ib >> amt; end
                    6'h07: begin amt = ia[4:0]; r = $signed(ib) >>> amt; end
                    default: begin r = 0; ill = 1'b1; end
                endcase
            end
        endcase
        if (amt > 0) lat = amt + 1;
    endtask

    task automatic scramble();
        alu_op = 3'($urandom); funct = 6'($urandom); shamt = 5'($urandom);
        a = $urandom; b = $urandom;
    endtask

    // Issue one request, measure latency, optionally stall in DONE, then retire it
    task automatic do_op(input string tag, input logic [2:0] op, input logic [5:0] fn,
                         input logic [4:0] sh, input logic [31:0] ia, input logic [31:0] ib,
                         input int stall, input bit hold);
        logic [31:0] er;
        logic        eil;
        int          elat;
        int          lat;
        int          guard;
        logic [31:0] held;
        model(op, fn, sh, ia, ib, er, eil, elat);
        alu_op = op; funct = fn; shamt = sh; a = ia; b = ib;
        in_valid = 1'b1; out_ready = 1'b0;
        guard = 0;
        while (!in_ready && guard < 200) begin @(posedge clk); #1; guard++; end
        check_eq({tag, ".ready"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        if (hold) scramble(); else in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
            if (hold) scramble();
        end
        check_eq({tag, ".lat"}, 64'(lat), 64'(elat));
        check_eq({tag, ".res"}, 64'(result), 64'(er));
        check_eq({tag, ".zero"}, 64'(zero), 64'(er == 0));
        check_eq({tag, ".ill"}, 64'(illegal), 64'(eil));
        held = result;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            if (hold) scramble();
            check_eq({tag, ".stall_valid"}, 64'(out_valid), 64'd1);
            check_eq({tag, ".stall_res"}, 64'(result), 64'(held));
            check_eq({tag, ".stall_rdy"}, 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq({tag, ".drop_valid"}, 64'(out_valid), 64'd0);
        check_eq({tag, ".idle_rdy"}, 64'(in_ready), 64'd1);
    endtask

    logic [5:0] legal_fn [14] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
                                  6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};

    initial begin
        int  lat8;
        bit  seen;
        logic [5:0] rfn;
        // Reset state while asserted
        #12;
        check_eq("rst.in_ready", 64'(in_ready), 64'd0);
        check_eq("rst.out_valid", 64'(out_valid), 64'd0);
        check_eq("rst.result", 64'(result), 64'd0);
        check_eq("rst.zero", 64'(zero), 64'd0);
        check_eq("rst.illegal", 64'(illegal), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_eq("rel.in_ready_pre", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        check_eq("rel.in_ready", 64'(in_ready), 64'd1);

        // Directed vectors
        do_op("add_wrap", 3'b001, 6'h00, 5'd0, 32'hFFFF_FFFF, 32'd1, 0, 0);
        do_op("slt", 3'b000, 6'h2A, 5'd0, 32'hFFFF_FFFF, 32'd1, 0, 0);
        do_op("sltu", 3'b000, 6'h2B, 5'd0, 32'hFFFF_FFFF, 32'd1, 0, 0);
        do_op("sra4", 3'b000, 6'h03, 5'd4, 32'd0, 32'h8000_0000, 0, 0);
        do_op("sra0", 3'b000, 6'h03, 5'd0, 32'd0, 32'h8000_0000, 0, 0);
        do_op("ill3f", 3'b000, 6'h3F, 5'd0, 32'd5, 32'd7, 0, 0);
        do_op("add3f", 3'b001, 6'h3F, 5'd0, 32'd5, 32'd7, 0, 0);
        do_op("nor", 3'b000, 6'h27, 5'd0, 32'h0F0F_0000, 32'h0000_00F0, 0, 0);
        do_op("srav31", 3'b000, 6'h07, 5'd0, 32'd31, 32'h8000_0001, 0, 0);
        do_op("stall_hold", 3'b000, 6'h00, 5'd3, 32'd0, 32'h1234_5678, 3, 1);

        // Randomised requests
        for (int i = 0; i < 60; i++) begin
            int k;
            k = $urandom_range(0, 15);
            rfn = (k < 14) ? legal_fn[k] : ((k == 14) ? 6'h3F : 6'h01);
            do_op("rand", ($urandom_range(0, 9) < 5) ? 3'b000 : 3'($urandom_range(1, 7)),
                  rfn, 5'($urandom), $urandom, $urandom, $urandom_range(0, 2),
                  1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a long variable shift
        alu_op = 3'b000; funct = 6'h06; a = 32'd31; b = 32'hDEAD_BEEF; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("abort.out_valid", 64'(out_valid), 64'd0);
        check_eq("abort.result", 64'(result), 64'd0);
        check_eq("abort.in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("abort.in_ready_after", 64'(in_ready), 64'd1);
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
        check_eq("abort.no_result", 64'(seen), 64'd0);

        // 8-bit instance: sra by 4 of 0x80
        alu_op8 = 3'b000; funct8 = 6'h03; shamt8 = 3'd4; b8 = 8'h80; in_valid8 = 1'b1;
        check_eq("w8.ready", 64'(in_ready8), 64'd1);
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        lat8 = 1;
        while (!out_valid8 && lat8 < 50) begin @(posedge clk); #1; lat8++; end
        check_eq("w8.lat", 64'(lat8), 64'd5);
        check_eq("w8.res", 64'(result8), 64'hF8);
        check_eq("w8.zero", 64'(zero8), 64'd0);
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
